colormap_rr_arbiter: RTL and testbench
======================================

Name: colormap_rr_arbiter

Overview:
Shares one gray-to-colour colormap engine between NUM_REQ independent pixel requesters. Each requester supplies its own 8-bit gray value and 3-bit colormap select. The block picks a winner by round-robin, sequences the engine's capture/process protocol, and returns the 24-bit RGB result with the requester ID on a shared response bus. A watchdog recovers from an engine that never answers. It sits between multi-channel capture front-ends and one instance of the colormap engine.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ), minimum 1.
TIMEOUT, 16, maximum cycles spent in WAIT before abort (range 4..255).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, synchronous, active-low.
req_valid  in  NUM_REQ  per-requester request valid.
req_gray  in  8*NUM_REQ  gray value; requester i uses bits [8i+7:8i].
req_sel  in  3*NUM_REQ  colormap select; requester i uses bits [3i+2:3i].
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
eng_valid  out  1  data_valid pulse to the engine.
eng_gray  out  8  gray value to the engine.
eng_sel  out  3  colormap select to the engine.
eng_r, eng_g, eng_b  in  8 each  engine result.
eng_out_valid  in  1  engine result valid.
rsp_valid  out  1  one-cycle response strobe.
rsp_id  out  ID_W  requester that owns the response.
rsp_rgb  out  24  {r,g,b} result; 0 on error.
rsp_err  out  1  response is a timeout abort.
busy  out  1  high whenever state is not IDLE.
timeout_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- All logic is on posedge clk. While rst_n=0 at an edge:
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first.
  - Every output is 0: eng_*, rsp_*, busy, timeout_sticky.
  - The wait counter is 0.
- Reset mid-operation abandons the in-flight pixel; no response is issued for it.
- FSM states:
  - IDLE:
    - req_ready is combinational and non-zero only here.
    - The winner is the first i with req_valid[i]=1, scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
    - req_ready = onehot(winner) if any req_valid is 1, else 0.
    - On a transfer: latch gray, sel and ID; set last_grant=winner; go to ISSUE.
  - ISSUE:
    - eng_valid=1 for exactly this cycle.
    - eng_gray/eng_sel are driven from the latched values and held stable through WAIT.
    - Clear the wait counter; go to WAIT.
  - WAIT:
    - The wait counter increments each cycle.
    - If eng_out_valid=1: register rsp_rgb={eng_r,eng_g,eng_b}, rsp_id=latched ID, rsp_err=0, rsp_valid=1; go to IDLE.
    - Else if the counter reaches TIMEOUT-1: register rsp_rgb=0, rsp_err=1, rsp_valid=1; set timeout_sticky; go to IDLE.
    - If both conditions hold in the same cycle, eng_out_valid wins and no error is flagged.
- rsp_valid, rsp_err and eng_valid are single-cycle pulses. rsp_rgb and rsp_id hold their value until the next response.
- eng_out_valid seen in IDLE or ISSUE is ignored. This covers stale engine output after a reset or a timeout.
- Nominal engine latency (capture in ISSUE, result two edges later):
  - Transfer edge to rsp_valid high: 4 cycles.
  - Sustained throughput: 1 pixel per 4 cycles.
  - A new grant can happen in the same cycle that rsp_valid is high, because the state is then IDLE.
- Requesters must hold req_valid, req_gray and req_sel stable until their ready is seen. Dropping req_valid before a grant is permitted and is not an error.
- Fairness: with all requesters valid continuously, the grant order is 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- busy = (state != IDLE), registered.

Test Plan:
- Single request, real engine attached: req 2 with gray=0x50, sel=0 → req_ready[2] for 1 cycle; eng_valid 1 cycle later; rsp_valid 4 cycles after the transfer with rsp_id=2, rsp_rgb=0x0040FF, rsp_err=0.
- All 4 requesters valid continuously for 12 grants, gray=0x10*i, sel=7 → grant order 0,1,2,3,0,1,2,3,0,1,2,3; each rsp_rgb = {g,g,g}; responses spaced exactly 4 cycles apart.
- Rotation pointer: grant 1 first, then only requesters 0 and 3 raise valid → grant 3, then 0.
- Engine stubbed never to answer, TIMEOUT=16 → rsp_valid with rsp_err=1, rsp_rgb=0 exactly 16 cycles after entering WAIT; timeout_sticky=1; next request is served normally; a late stray eng_out_valid in IDLE produces no response.
- Assert rst_n=0 for 1 cycle during WAIT → next cycle all outputs 0, busy=0; no response for the aborted pixel; first grant afterwards goes to requester 0 when requesters 0 and 1 are both valid.
- eng_out_valid and timeout in the same WAIT cycle (stub answers at count TIMEOUT-1) → rsp_err=0, real RGB returned, timeout_sticky stays 0.

Source files
------------

// File: rtl/colormap_rr_arbiter_if.sv
// rtl/colormap_rr_arbiter_if.sv - requester, engine and response bundle for the colormap arbiter
interface colormap_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_gray;
    logic [3*NUM_REQ-1:0] req_sel;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 eng_valid;
    logic [7:0]           eng_gray;
    logic [2:0]           eng_sel;
    logic [7:0]           eng_r;
    logic [7:0]           eng_g;
    logic [7:0]           eng_b;
    logic                 eng_out_valid;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [23:0]          rsp_rgb;
    logic                 rsp_err;
    logic                 busy;
    logic                 timeout_sticky;

    modport slave (
        input  req_valid, req_gray, req_sel, eng_r, eng_g, eng_b, eng_out_valid,
        output req_ready, eng_valid, eng_gray, eng_sel,
        output rsp_valid, rsp_id, rsp_rgb, rsp_err, busy, timeout_sticky
    );

    modport master (
        output req_valid, req_gray, req_sel, eng_r, eng_g, eng_b, eng_out_valid,
        input  req_ready, eng_valid, eng_gray, eng_sel,
        input  rsp_valid, rsp_id, rsp_rgb, rsp_err, busy, timeout_sticky
    );
endinterface

// File: rtl/colormap_rr_arbiter.sv
// rtl/colormap_rr_arbiter.sv - round-robin share of one colormap engine with timeout recovery
module colormap_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    colormap_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        gray_q;
    logic [2:0]        sel_q;
    logic [7:0]        wait_cnt_q;
    logic              eng_valid_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [23:0]       rsp_rgb_q;
    logic              busy_q;
    logic              sticky_q;

    logic              win_found;
    int                win_int;
    logic [ID_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] ready_onehot;

    // Scan starts just after the last winner so every requester is reached within NUM_REQ grants.
    always_comb begin
        win_found = 1'b0;
        win_int   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_int   = (int'(last_grant_q) + k) % NUM_REQ;
            end
        end
        win_idx      = ID_W'(win_int);
        ready_onehot = '0;
        if (state_q == IDLE && win_found) begin
            ready_onehot[win_int] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            gray_q       <= '0;
            sel_q        <= '0;
            wait_cnt_q   <= '0;
            eng_valid_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_rgb_q    <= '0;
            busy_q       <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            eng_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gray_q       <= bus.req_gray[8*win_int +: 8];
                        sel_q        <= bus.req_sel[3*win_int +: 3];
                        id_q         <= win_idx;
                        last_grant_q <= win_idx;
                        eng_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still counts as success.
                    if (bus.eng_out_valid) begin
                        rsp_rgb_q   <= {bus.eng_r, bus.eng_g, bus.eng_b};
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                        rsp_rgb_q   <= '0;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        sticky_q    <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = ready_onehot;
    assign bus.eng_valid      = eng_valid_q;
    assign bus.eng_gray       = gray_q;
    assign bus.eng_sel        = sel_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_rgb        = rsp_rgb_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.busy           = busy_q;
    assign bus.timeout_sticky = sticky_q;
endmodule

// File: tb/tb_colormap_rr_arbiter.sv
// tb/tb_colormap_rr_arbiter.sv - self-checking bench for colormap_rr_arbiter with a behavioural engine
module tb_colormap_rr_arbiter;
    localparam int N = 4;

    typedef struct {
        int          id;
        logic [23:0] rgb;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    colormap_rr_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

    colormap_rr_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   model_last = 3;
    int   eng_dly    = 1;
    bit   eng_mute   = 1'b0;
    bit   stray      = 1'b0;
    int   eng_cnt    = 0;
    logic [23:0] eng_res = '0;

    logic [3:0] v;
    logic [7:0] g [N];
    logic [2:0] s [N];
    exp_t       q [$];

    function automatic logic [23:0] cmap(input logic [7:0] x, input logic [2:0] sel);
        int xi;
        xi = int'(x);
        case (sel)
            3'd0: begin
                if (xi < 64)       return {8'h00, 8'h00, 8'(128 + 2*xi)};
                else if (xi < 128) return {8'h00, 8'((xi-64)*4), 8'hFF};
                else if (xi < 192) return {8'((xi-128)*4), 8'hFF, 8'(255-(xi-128)*4)};
                else               return {8'hFF, 8'(255-(xi-192)*4), 8'h00};
            end
            3'd7:    return {x, x, x};
            default: return {x, ~x, x ^ {5'b0, sel}};
        endcase
    endfunction

    function automatic int rr_pick(input logic [3:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: captures on eng_valid, answers eng_dly edges later; stray injects an unsolicited result.
    always @(posedge clk) begin
        bus.eng_out_valid <= stray;
        if (stray) {bus.eng_r, bus.eng_g, bus.eng_b} <= 24'hABCDEF;
        if (bus.eng_valid === 1'b1 && !eng_mute) begin
            eng_cnt <= eng_dly;
            eng_res <= cmap(bus.eng_gray, bus.eng_sel);
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                bus.eng_out_valid <= 1'b1;
                {bus.eng_r, bus.eng_g, bus.eng_b} <= eng_res;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = v[i];
            bus.req_gray[8*i +: 8] = g[i];
            bus.req_sel[3*i +: 3]  = s[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v = '0;
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        eng_dly = 1;
        eng_mute = 1'b0;
    endtask

    task automatic send_one(input int id, output int gcyc, output logic [3:0] rdy);
        v[id] = 1'b1;
        drive();
        #1;
        for (int t = 0; t < 40 && bus.req_ready === 4'b0; t++) @(negedge clk);
        rdy  = bus.req_ready;
        gcyc = cyc;
        @(negedge clk);
        v[id] = 1'b0;
        drive();
    endtask

    task automatic wait_rsp(output int rcyc);
        for (int t = 0; t < 60 && bus.rsp_valid !== 1'b1; t++) @(negedge clk);
        rcyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v = '0;
        for (int i = 0; i < N; i++) begin g[i] = '0; s[i] = '0; end
        drive();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.eng_valid, bus.eng_gray, bus.eng_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb,
             bus.rsp_err, bus.busy, bus.timeout_sticky} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {bus.eng_valid, bus.eng_gray, bus.eng_sel,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, bus.rsp_err, bus.busy, bus.timeout_sticky});
        end
        n_cmp++;
        if (bus.req_ready !== 4'b0) begin
            n_err++; $display("FAIL reset_ready_idle: got %b want 0000", bus.req_ready);
        end
        v = 4'b1111;
        drive();
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'(1 << rr_pick(v, 3))) begin
            n_err++; $display("FAIL reset_first_winner: got %b want 0001", bus.req_ready);
        end
        @(negedge clk);
        v = '0;
        drive();
        rst_n = 1'b1;
        model_last = 3;
    endtask

    task automatic test_single();
        int gcyc, rcyc;
        logic [3:0] rdy;
        g[2] = 8'h50; s[2] = 3'd0;
        send_one(2, gcyc, rdy);
        n_cmp++;
        if (rdy !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", rdy); end
        n_cmp++;
        if ({bus.eng_valid, bus.eng_gray, bus.eng_sel, bus.busy, bus.req_ready} !== {1'b1, 8'h50, 3'd0, 1'b1, 4'b0}) begin
            n_err++;
            $display("FAIL single_issue: got v=%b g=%h s=%0d busy=%b rdy=%b want v=1 g=50 s=0 busy=1 rdy=0000",
                     bus.eng_valid, bus.eng_gray, bus.eng_sel, bus.busy, bus.req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.eng_valid, bus.eng_gray} !== {1'b0, 8'h50}) begin
            n_err++; $display("FAIL single_eng_pulse: got v=%b g=%h want v=0 g=50", bus.eng_valid, bus.eng_gray);
        end
        wait_rsp(rcyc);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || rcyc - gcyc != 4 || bus.rsp_id !== 2'd2 ||
            bus.rsp_rgb !== 24'h0040FF || bus.rsp_err !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b lat=%0d id=%0d rgb=%h err=%b busy=%b want v=1 lat=4 id=2 rgb=0040ff err=0 busy=0",
                     bus.rsp_valid, rcyc - gcyc, bus.rsp_id, bus.rsp_rgb, bus.rsp_err, bus.busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_rgb, bus.rsp_id} !== {1'b0, 24'h0040FF, 2'd2}) begin
            n_err++;
            $display("FAIL single_hold: got v=%b rgb=%h id=%0d want v=0 rgb=0040ff id=2",
                     bus.rsp_valid, bus.rsp_rgb, bus.rsp_id);
        end
    endtask

    task automatic test_back_to_back();
        int grants, rsps, last_r;
        exp_t e;
        do_reset();
        for (int i = 0; i < N; i++) begin g[i] = 8'(16 * i); s[i] = 3'd7; end
        v = 4'hF;
        drive();
        #1;
        grants = 0; rsps = 0; last_r = -1;
        q.delete();
        for (int c = 0; c < 200 && rsps < 12; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : '{id: -1, rgb: 24'h0};
                n_cmp++;
                if (bus.rsp_id !== 2'(e.id) || bus.rsp_rgb !== e.rgb || bus.rsp_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_rsp: got id=%0d rgb=%h err=%b want id=%0d rgb=%h err=0",
                             bus.rsp_id, bus.rsp_rgb, bus.rsp_err, e.id, e.rgb);
                end
                if (last_r >= 0) begin
                    n_cmp++;
                    if (cyc - last_r != 4) begin
                        n_err++; $display("FAIL b2b_spacing: got %0d want 4", cyc - last_r);
                    end
                end
                last_r = cyc;
                rsps++;
            end
            if (grants == 12) begin v = '0; drive(); #1; end
            if (grants < 12 && bus.req_ready !== 4'b0) begin
                n_cmp++;
                if (bus.req_ready !== 4'(1 << (grants % N))) begin
                    n_err++; $display("FAIL b2b_order: grant %0d got %b want id %0d", grants, bus.req_ready, grants % N);
                end
                q.push_back('{id: grants % N, rgb: {3{8'(16 * (grants % N))}}});
                grants++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rsps != 12) begin n_err++; $display("FAIL b2b_count: got %0d want 12", rsps); end
    endtask

    task automatic test_rotation();
        do_reset();
        v = 4'b0010;
        drive();
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'(1 << rr_pick(4'b0010, 3))) begin
            n_err++; $display("FAIL rot_first: got %b want 0010", bus.req_ready);
        end
        @(negedge clk);
        v = 4'b1001;
        drive();
        #1;
        for (int t = 0; t < 40 && bus.req_ready === 4'b0; t++) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 4'(1 << rr_pick(4'b1001, 1))) begin
            n_err++; $display("FAIL rot_second: got %b want 1000", bus.req_ready);
        end
        @(negedge clk);
        v[3] = 1'b0;
        drive();
        #1;
        for (int t = 0; t < 40 && bus.req_ready === 4'b0; t++) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 4'(1 << rr_pick(4'b0001, 3))) begin
            n_err++; $display("FAIL rot_third: got %b want 0001", bus.req_ready);
        end
        @(negedge clk);
        v = '0;
        drive();
        model_last = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_same_cycle();
        int gcyc, rcyc;
        logic [3:0] rdy;
        eng_dly = 15;
        g[2] = 8'h20; s[2] = 3'd5;
        send_one(2, gcyc, rdy);
        wait_rsp(rcyc);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || rcyc - gcyc != 18 || bus.rsp_err !== 1'b0 ||
            bus.rsp_rgb !== cmap(8'h20, 3'd5) || bus.timeout_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL same_cycle: got v=%b lat=%0d err=%b rgb=%h sticky=%b want v=1 lat=18 err=0 rgb=%h sticky=0",
                     bus.rsp_valid, rcyc - gcyc, bus.rsp_err, bus.rsp_rgb, bus.timeout_sticky, cmap(8'h20, 3'd5));
        end
        eng_dly = 1;
        model_last = 2;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int gcyc, rcyc, cnt;
        logic [3:0] rdy;
        eng_mute = 1'b1;
        g[1] = 8'h33; s[1] = 3'd2;
        send_one(1, gcyc, rdy);
        wait_rsp(rcyc);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || rcyc - gcyc != 18 || bus.rsp_err !== 1'b1 || bus.rsp_rgb !== 24'h0 ||
            bus.rsp_id !== 2'd1 || bus.timeout_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_rsp: got v=%b lat=%0d err=%b rgb=%h id=%0d sticky=%b want v=1 lat=18 err=1 rgb=0 id=1 sticky=1",
                     bus.rsp_valid, rcyc - gcyc, bus.rsp_err, bus.rsp_rgb, bus.rsp_id, bus.timeout_sticky);
        end
        eng_mute = 1'b0;
        g[3] = 8'h80; s[3] = 3'd0;
        @(negedge clk);
        send_one(3, gcyc, rdy);
        wait_rsp(rcyc);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || rcyc - gcyc != 4 || bus.rsp_err !== 1'b0 || bus.rsp_rgb !== 24'h00FFFF ||
            bus.rsp_id !== 2'd3 || bus.timeout_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL after_timeout: got v=%b lat=%0d err=%b rgb=%h id=%0d sticky=%b want v=1 lat=4 err=0 rgb=00ffff id=3 sticky=1",
                     bus.rsp_valid, rcyc - gcyc, bus.rsp_err, bus.rsp_rgb, bus.rsp_id, bus.timeout_sticky);
        end
        @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        cnt = 0;
        repeat (6) begin
            if (bus.rsp_valid === 1'b1) cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 0) begin n_err++; $display("FAIL stray_ignored: got %0d responses want 0", cnt); end
        model_last = 3;
    endtask

    task automatic test_reset_mid();
        int gcyc, rcyc;
        logic [3:0] rdy;
        g[2] = 8'h40; s[2] = 3'd3;
        g[0] = 8'hC8; s[0] = 3'd1;
        g[1] = 8'h11; s[1] = 3'd4;
        send_one(2, gcyc, rdy);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if ({bus.eng_valid, bus.eng_gray, bus.eng_sel, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb,
             bus.rsp_err, bus.busy, bus.timeout_sticky, bus.req_ready} !== 46'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h want 0", {bus.eng_valid, bus.eng_gray, bus.eng_sel,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, bus.rsp_err, bus.busy, bus.timeout_sticky, bus.req_ready});
        end
        model_last = 3;
        v = 4'b0011;
        drive();
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'(1 << rr_pick(v, model_last))) begin
            n_err++; $display("FAIL midreset_grant: got %b want 0001", bus.req_ready);
        end
        gcyc = cyc;
        @(negedge clk);
        v = '0;
        drive();
        wait_rsp(rcyc);
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || rcyc - gcyc != 4 || bus.rsp_id !== 2'd0 ||
            bus.rsp_rgb !== cmap(8'hC8, 3'd1) || bus.rsp_err !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_rsp: got v=%b lat=%0d id=%0d rgb=%h err=%b want v=1 lat=4 id=0 rgb=%h err=0",
                     bus.rsp_valid, rcyc - gcyc, bus.rsp_id, bus.rsp_rgb, bus.rsp_err, cmap(8'hC8, 3'd1));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int grants, ex;
        logic [3:0] gp, want;
        exp_t e;
        do_reset();
        eng_dly = $urandom_range(1, 6);
        q.delete();
        gp = '0;
        grants = 0;
        for (int c = 0; c < 3000 && !(grants >= 40 && q.size() == 0); c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL rand_rsp: got unexpected id=%0d want none", bus.rsp_id);
                end else begin
                    e = q.pop_front();
                    if (bus.rsp_id !== 2'(e.id) || bus.rsp_rgb !== e.rgb || bus.rsp_err !== 1'b0) begin
                        n_err++;
                        $display("FAIL rand_rsp: got id=%0d rgb=%h err=%b want id=%0d rgb=%h err=0",
                                 bus.rsp_id, bus.rsp_rgb, bus.rsp_err, e.id, e.rgb);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (grants >= 40) begin
                    v[i] = 1'b0;
                end else if (gp[i] || !v[i]) begin
                    if (gp[i] || $urandom_range(0, 2) == 0) begin
                        v[i] = 1'($urandom_range(0, 1)) | ~gp[i];
                        g[i] = 8'($urandom);
                        s[i] = 3'($urandom);
                    end
                end else if (q.size() != 0 && $urandom_range(0, 9) == 0) begin
                    v[i] = 1'b0;
                end
            end
            drive();
            #1;
            gp = '0;
            ex = (q.size() == 0) ? rr_pick(v, model_last) : -1;
            want = (ex >= 0) ? 4'(1 << ex) : 4'b0;
            n_cmp++;
            if (bus.req_ready !== want) begin
                n_err++; $display("FAIL rand_grant: cycle %0d got %b want %b", cyc, bus.req_ready, want);
            end
            if (ex >= 0) begin
                q.push_back('{id: ex, rgb: cmap(g[ex], s[ex])});
                model_last = ex;
                gp[ex] = 1'b1;
                grants++;
            end
        end
        n_cmp++;
        if (q.size() != 0 || grants < 40) begin
            n_err++; $display("FAIL rand_drain: got grants=%0d pending=%0d want grants=40 pending=0", grants, q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v = '0;
        for (int i = 0; i < N; i++) begin g[i] = '0; s[i] = '0; end
        drive();
        test_reset();
        test_single();
        test_back_to_back();
        test_rotation();
        test_same_cycle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
